// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode, field and pipeline-control definitions
package cpu_defs;

    // Instruction field positions: R1 = [7:6], R2 = [5:4], opcode = [3:0]
    localparam int R1_HI = 7;
    localparam int R1_LO = 6;
    localparam int R2_HI = 5;
    localparam int R2_LO = 4;
    localparam int OP_HI = 3;
    localparam int OP3_HI = 2;

    // Full 4-bit opcodes; none of these end in 3'b011 or 3'b111, which
    // are taken by the 3-bit shift/ori encodings below.
    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STOP  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_BZ    = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_NAND  = 4'h8;
    localparam logic [3:0] OP_BNZ   = 4'h9;
    localparam logic [3:0] OP_NOP   = 4'hA;
    localparam logic [3:0] OP_BPZ   = 4'hD;

    // 3-bit opcodes; upper instruction bits carry an immediate
    localparam logic [2:0] OP3_SHIFT = 3'b011;
    localparam logic [2:0] OP3_ORI   = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Destination metadata carried by X, M and W
    typedef struct packed {
        logic       valid;
        logic       writes;
        logic [1:0] dest;
    } stage_t;

endpackage

// File: rtl/instr_regs_decode.sv
// rtl/instr_regs_decode.sv - register read/write usage decode of one instruction
module instr_regs_decode
    import cpu_defs::*;
#(
    parameter logic [1:0] REG_K1 = 2'd1
) (
    input  logic [7:0] instr,
    output logic       reads_a,
    output logic [1:0] reg_a,
    output logic       reads_b,
    output logic [1:0] reg_b,
    output logic       writes,
    output logic [1:0] dest,
    output logic       is_stop
);

    logic [1:0] r1;
    logic [1:0] r2;

    assign r1 = instr[R1_HI:R1_LO];
    assign r2 = instr[R2_HI:R2_LO];

    // Operand and destination usage; 3-bit opcodes are matched first
    always_comb begin
        reads_a = 1'b0;
        reg_a   = 2'd0;
        reads_b = 1'b0;
        reg_b   = 2'd0;
        writes  = 1'b0;
        dest    = 2'd0;
        is_stop = 1'b0;
        if (instr[OP3_HI:0] == OP3_ORI) begin
            reads_a = 1'b1;
            reg_a   = REG_K1;
            writes  = 1'b1;
            dest    = REG_K1;
        end else if (instr[OP3_HI:0] == OP3_SHIFT) begin
            reads_a = 1'b1;
            reg_a   = r1;
            writes  = 1'b1;
            dest    = r1;
        end else begin
            case (instr[OP_HI:0])
                OP_LOAD: begin
                    reads_a = 1'b1;
                    reg_a   = r2;
                    writes  = 1'b1;
                    dest    = r1;
                end
                OP_STORE: begin
                    reads_a = 1'b1;
                    reg_a   = r1;
                    reads_b = 1'b1;
                    reg_b   = r2;
                end
                OP_ADD, OP_SUB, OP_NAND: begin
                    reads_a = 1'b1;
                    reg_a   = r1;
                    reads_b = 1'b1;
                    reg_b   = r2;
                    writes  = 1'b1;
                    dest    = r1;
                end
                OP_STOP: is_stop = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_hazard.sv
// rtl/control_hazard.sv - decode-stage hazard stall, branch flush and stop drain control
module control_hazard
    import cpu_defs::*;
#(
    parameter bit         WB_BYPASS = 1'b0,
    parameter logic [1:0] REG_K1    = 2'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ir1,
    input  logic       ir1_valid,
    input  logic       branch_taken,
    output logic       stall,
    output logic       flush,
    output logic       ir2_load,
    output logic       x_valid,
    output logic       m_valid,
    output logic       w_valid,
    output logic       rf_write,
    output logic [1:0] rf_wdest,
    output logic       halted
);

    stage_t x_q, m_q, w_q, x_next;
    state_t state;

    logic       reads_a, reads_b, writes, is_stop;
    logic [1:0] reg_a, reg_b, dest;
    logic       hazard, active;

    instr_regs_decode #(.REG_K1(REG_K1)) u_decode (
        .instr   (ir1),
        .reads_a (reads_a),
        .reg_a   (reg_a),
        .reads_b (reads_b),
        .reg_b   (reg_b),
        .writes  (writes),
        .dest    (dest),
        .is_stop (is_stop)
    );

    function automatic logic writes_reg(input stage_t s, input logic [1:0] r);
        return s.valid & s.writes & (s.dest == r);
    endfunction

    // A write-through register file makes a writer in W harmless
    function automatic logic pending_write(input logic [1:0] r);
        return writes_reg(x_q, r) | writes_reg(m_q, r)
             | ((WB_BYPASS == 1'b0) & writes_reg(w_q, r));
    endfunction

    assign hazard = ir1_valid & ((reads_a & pending_write(reg_a))
                               | (reads_b & pending_write(reg_b)));

    // Control outputs are silenced while in reset and once halted
    assign active   = !reset && (state != ST_HALT);
    assign flush    = active & branch_taken & x_q.valid;
    assign stall    = active & hazard & !flush;
    assign ir2_load = active & ir1_valid & !stall & !flush
                    & (state == ST_RUN) & !is_stop;

    assign x_next   = ir2_load ? '{valid: 1'b1, writes: writes, dest: dest} : '0;

    assign x_valid  = x_q.valid;
    assign m_valid  = m_q.valid;
    assign w_valid  = w_q.valid;
    assign rf_write = w_q.valid & w_q.writes;
    assign rf_wdest = w_q.dest;
    assign halted   = (state == ST_HALT);

    // Stage shift X->M->W and the run/drain/halt state machine
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            state <= ST_RUN;
        end else begin
            x_q <= x_next;
            m_q <= x_q;
            w_q <= m_q;
            case (state)
                ST_RUN:
                    if (ir1_valid && is_stop && !flush)
                        state <= ST_DRAIN;
                ST_DRAIN:
                    if (flush)
                        state <= ST_RUN;
                    else if (!x_q.valid && !m_q.valid && !w_q.valid)
                        state <= ST_HALT;
                default:
                    state <= ST_HALT;
            endcase
        end
    end

endmodule
